// File: rtl/gpio_input_port.sv
// GPIO input port: 32 pins, each synchronised, debounced on a divided tick, with a sticky
// masked rising-edge flag. The core reads and writes it through LDR/STR micro-ops on falling edges.

module gpio_in_lane (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic tick,
  input  logic mask,
  input  logic clr,
  output logic stable,
  output logic flag,
  output logic flag_nxt
);
  logic sync1, sync2, sample;
  logic stable_nxt, rise;

  always_comb begin
    stable_nxt = stable;
    if (tick && (sync2 == sample)) stable_nxt = sync2;
    rise     = stable_nxt & ~stable & mask;
    // Set beats clear when a rise lands on the read-to-clear cycle.
    flag_nxt = (flag & ~clr) | rise;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sample <= 1'b0;
      stable <= 1'b0;
      flag   <= 1'b0;
    end else begin
      sync1  <= pin;
      sync2  <= sync1;
      if (tick) sample <= sync2;
      stable <= stable_nxt;
      flag   <= flag_nxt;
    end
  end
endmodule

module gpio_input_port #(
  parameter logic [4:0]  LDR_UOP        = 5'd8,
  parameter logic [4:0]  STR_UOP        = 5'd9,
  parameter logic [31:0] PIN_ADDR       = 32'd36,
  parameter logic [31:0] EDGE_ADDR      = 32'd40,
  parameter logic [31:0] MASK_ADDR      = 32'd44,
  parameter int          DEBOUNCE_TICKS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  uop,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pins_in,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        irq
);
  localparam int NUM_LANES = 32;
  localparam int CNT_W     = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  logic [CNT_W-1:0]     tick_cnt;
  logic                 tick;
  logic [NUM_LANES-1:0] stable, edge_q, edge_nxt, mask_q;
  logic [31:0]          rd_nxt;
  logic                 hit, clr;

  assign tick = (tick_cnt == CNT_W'(DEBOUNCE_TICKS - 1));

  always_comb begin
    rd_nxt = rdata;
    hit    = 1'b0;
    clr    = 1'b0;
    if (uop == LDR_UOP) begin
      case (addr)
        PIN_ADDR:  begin rd_nxt = stable; hit = 1'b1; end
        EDGE_ADDR: begin rd_nxt = edge_q; hit = 1'b1; clr = 1'b1; end
        MASK_ADDR: begin rd_nxt = mask_q; hit = 1'b1; end
        default:   ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    gpio_in_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .pin      (pins_in[g]),
      .tick     (tick),
      .mask     (mask_q[g]),
      .clr      (clr),
      .stable   (stable[g]),
      .flag     (edge_q[g]),
      .flag_nxt (edge_nxt[g])
    );
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      mask_q   <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
      if (uop == STR_UOP && addr == MASK_ADDR) mask_q <= wdata;
      rdata    <= rd_nxt;
      rvalid   <= hit;
      irq      <= |edge_nxt;
    end
  end
endmodule

// File: tb/tb_gpio_input_port.sv
// Directed bench for gpio_input_port: one instance with a 4-cycle debounce tick, one with 1.
`timescale 1ns/1ps
module tb_gpio_input_port;
  localparam logic [4:0] LDR = 5'd8;
  localparam logic [4:0] STR = 5'd9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  uop = '0;
  logic [31:0] addr = '0, wdata = '0, pins_in = '0;
  logic [31:0] rdata4, rdata1;
  logic        rvalid4, rvalid1, irq4, irq1;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  gpio_input_port #(.DEBOUNCE_TICKS(4)) u4 (
    .clk(clk), .rst(rst), .uop(uop), .addr(addr), .wdata(wdata), .pins_in(pins_in),
    .rdata(rdata4), .rvalid(rvalid4), .irq(irq4)
  );
  gpio_input_port #(.DEBOUNCE_TICKS(1)) u1 (
    .clk(clk), .rst(rst), .uop(uop), .addr(addr), .wdata(wdata), .pins_in(pins_in),
    .rdata(rdata1), .rvalid(rvalid1), .irq(irq1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  // State updates on the falling edge; everything is driven and sampled 1ns after it.
  task automatic cyc(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic op(input logic [4:0] u, input logic [31:0] a, input logic [31:0] d = '0);
    uop = u; addr = a; wdata = d;
    cyc();
    uop = '0; addr = '0; wdata = '0;
  endtask

  initial begin
    // 1: reset state, then a held pin reaches stable on the 8th edge after release
    pins_in = 32'h1;
    cyc(2);
    chk("rst_rdata", rdata4, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid4}, 32'h0);
    chk("rst_irq", {31'h0, irq4}, 32'h0);
    rst = 1'b0;
    cyc(7);
    chk("stable_early", u4.stable, 32'h0);
    cyc(1);
    chk("stable_8", u4.stable, 32'h1);
    cyc(1);
    op(LDR, 32'd36);
    chk("ld_pin", rdata4, 32'h1);
    chk("ld_pin_vld", {31'h0, rvalid4}, 32'h1);
    cyc(1);
    chk("vld_drop", {31'h0, rvalid4}, 32'h0);

    // 2: 3-cycle glitch on pin 3 is shorter than two ticks
    pins_in = 32'h9;
    cyc(3);
    pins_in = 32'h1;
    cyc(12);
    op(LDR, 32'd36);
    chk("glitch_pin", rdata4, 32'h1);
    chk("glitch_edge", u4.edge_q, 32'h0);

    // 3: masked edges and read-to-clear
    op(STR, 32'd44, 32'h0000_00F0);
    op(LDR, 32'd44);
    chk("ld_mask", rdata4, 32'hF0);
    pins_in = 32'h111;
    for (int k = 0; k < 16 && !irq4; k++) cyc();
    chk("irq_set", {31'h0, irq4}, 32'h1);
    chk("edge_10", u4.edge_q, 32'h10);
    op(LDR, 32'd40);
    chk("ld_edge", rdata4, 32'h10);
    chk("edge_clr", u4.edge_q, 32'h0);
    chk("irq_clr", {31'h0, irq4}, 32'h0);

    // 4: read-to-clear on the cycle pin 5 stabilises; set wins
    pins_in = 32'h131;
    cyc(2);
    for (int k = 0; k < 8 && !u4.tick; k++) cyc();
    chk("tick_a", {31'h0, u4.tick}, 32'h1);
    cyc(1);
    for (int k = 0; k < 8 && !u4.tick; k++) cyc();
    chk("tick_b", {31'h0, u4.tick}, 32'h1);
    chk("pre_stable5", {31'h0, u4.stable[5]}, 32'h0);
    op(LDR, 32'd40);
    chk("race_rdata", rdata4, 32'h0);
    chk("race_edge", u4.edge_q, 32'h20);
    chk("race_irq", {31'h0, irq4}, 32'h1);

    // 5: build edge=0xF0, then asynchronous reset between clock edges
    pins_in = 32'h1E1;
    cyc(12);
    pins_in = 32'h1F1;
    cyc(12);
    chk("edge_f0", u4.edge_q, 32'hF0);
    op(LDR, 32'd44);
    chk("pre_rst_rdata", rdata4, 32'hF0);
    #2 rst = 1'b1;
    #1;
    chk("arst_edge", u4.edge_q, 32'h0);
    chk("arst_mask", u4.mask_q, 32'h0);
    chk("arst_rdata", rdata4, 32'h0);
    chk("arst_irq", {31'h0, irq4}, 32'h0);
    rst = 1'b0;
    cyc(1);
    op(STR, 32'd36, 32'hFF);
    op(LDR, 32'd44);
    chk("str_other", rdata4, 32'h0);
    chk("ld_mask_vld", {31'h0, rvalid4}, 32'h1);
    cyc(12);
    op(LDR, 32'd36);
    chk("pin_after_rst", rdata4, 32'h1F1);
    chk("edge_lost", u4.edge_q, 32'h0);
    op(LDR, 32'd48);
    chk("miss_vld", {31'h0, rvalid4}, 32'h0);
    chk("miss_rdata", rdata4, 32'h1F1);

    // 6: DEBOUNCE_TICKS=1, all 32 pins rise together
    pins_in = '0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    op(STR, 32'd44, 32'hFFFF_FFFF);
    pins_in = 32'hFFFF_FFFF;
    cyc(5);
    chk("all_stable", u1.stable, 32'hFFFF_FFFF);
    chk("all_edge", u1.edge_q, 32'hFFFF_FFFF);
    chk("all_irq", {31'h0, irq1}, 32'h1);
    op(LDR, 32'd40);
    chk("all_ld_edge", rdata1, 32'hFFFF_FFFF);
    chk("all_irq_clr", {31'h0, irq1}, 32'h0);
    chk("all_edge_clr", u1.edge_q, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
